// File: rtl/cnn_window_feeder_if.sv
// Bus bundle between the window feeder and its environment: pixel loader, CNN core and result sink.
// The master modport is the feeder side; the slave modport is the environment side.
interface cnn_window_feeder_if #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned WIN     = 5,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned CLS_W   = 4
);
  localparam int unsigned IMG_W = WIN * WIN * PIX_W;

  logic               pix_valid;
  logic [PIX_W-1:0]   pix_data;
  logic               pix_ready;
  logic               go;
  logic               busy;
  logic               cnn_start;
  logic [COORD_W-1:0] cnn_x;
  logic [COORD_W-1:0] cnn_y;
  logic [IMG_W-1:0]   cnn_imgin;
  logic               cnn_done;
  logic [CLS_W-1:0]   cnn_out;
  logic               res_valid;
  logic [CLS_W-1:0]   res_class;
  logic [COORD_W-1:0] res_x;
  logic [COORD_W-1:0] res_y;
  logic               frame_done;
  logic               err_timeout;

  modport master (
    input  pix_valid, pix_data, go, cnn_done, cnn_out,
    output pix_ready, busy, cnn_start, cnn_x, cnn_y, cnn_imgin,
           res_valid, res_class, res_x, res_y, frame_done, err_timeout
  );

  modport slave (
    output pix_valid, pix_data, go, cnn_done, cnn_out,
    input  pix_ready, busy, cnn_start, cnn_x, cnn_y, cnn_imgin,
           res_valid, res_class, res_x, res_y, frame_done, err_timeout
  );
endinterface

// File: rtl/cnn_window_feeder.sv
// Buffers one raster-loaded frame, then drives every WINxWIN window through the CNN core
// start/done handshake and emits each returned class tagged with its window origin.
module cnn_window_feeder #(
  parameter int unsigned IMG_DIM = 28,
  parameter int unsigned WIN     = 5,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cnn_window_feeder_if.master  bus
);
  localparam int unsigned POS     = IMG_DIM - WIN + 1;
  localparam int unsigned NPIX    = IMG_DIM * IMG_DIM;
  localparam int unsigned CNT_W   = $clog2(NPIX + 1);
  localparam int unsigned ADDR_W  = $clog2(NPIX);
  localparam int unsigned COORD_W = $clog2(POS);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned IMG_W   = WIN * WIN * PIX_W;

  typedef enum logic [2:0] {LOAD, LOADED, ISSUE, WAIT_DONE, EMIT} state_t;

  state_t             state;
  state_t             next_state;
  logic [PIX_W-1:0]   mem [NPIX];
  logic [CNT_W-1:0]   count;
  logic [TMR_W-1:0]   timer;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic [IMG_W-1:0]   win_c;
  logic               accept_c;
  logic               timeout_c;
  logic               last_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  // Next state, handshake events and the coordinates of the next window to issue
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    timeout_c  = 1'b0;
    last_c     = (bus.cnn_x == COORD_W'(POS - 1)) && (bus.cnn_y == COORD_W'(POS - 1));
    nx         = bus.cnn_x;
    ny         = bus.cnn_y;
    case (state)
      LOAD: begin
        if (bus.pix_valid && bus.pix_ready) begin
          accept_c = 1'b1;
          if (count == CNT_W'(NPIX - 1)) next_state = LOADED;
        end
      end
      LOADED: begin
        if (bus.go) begin
          next_state = ISSUE;
          nx         = '0;
          ny         = '0;
        end
      end
      ISSUE: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.cnn_done) begin
          next_state = EMIT;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          timeout_c  = 1'b1;
          next_state = LOAD;
        end
      end
      EMIT: begin
        if (last_c) begin
          next_state = LOAD;
        end else begin
          next_state = ISSUE;
          if (bus.cnn_x == COORD_W'(POS - 1)) begin
            nx = '0;
            ny = bus.cnn_y + COORD_W'(1);
          end else begin
            nx = bus.cnn_x + COORD_W'(1);
          end
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // Window gather for the coordinates about to be issued
  always_comb begin
    win_c = '0;
    for (int unsigned k = 0; k < WIN; k++) begin
      for (int unsigned l = 0; l < WIN; l++) begin
        win_c[(k*WIN + l)*PIX_W +: PIX_W] =
          mem[ADDR_W'((32'(ny) + k) * IMG_DIM + 32'(nx) + l)];
      end
    end
  end

  // Frame buffer keeps old contents until overwritten
  always_ff @(posedge clk) begin
    if (accept_c) mem[count[ADDR_W-1:0]] <= bus.pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count           <= '0;
      timer           <= '0;
      bus.pix_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.cnn_start   <= 1'b0;
      bus.cnn_x       <= '0;
      bus.cnn_y       <= '0;
      bus.cnn_imgin   <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_class   <= '0;
      bus.res_x       <= '0;
      bus.res_y       <= '0;
      bus.frame_done  <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.pix_ready  <= (next_state == LOAD);
      bus.busy       <= (next_state inside {ISSUE, WAIT_DONE, EMIT});
      bus.cnn_start  <= (next_state == ISSUE);
      bus.res_valid  <= (next_state == EMIT);
      bus.frame_done <= (state == EMIT) && last_c;

      if (accept_c)                                    count <= count + CNT_W'(1);
      else if (next_state == LOAD && state != LOAD)    count <= '0;

      if (timeout_c)                                   bus.err_timeout <= 1'b1;
      else if (accept_c && count == '0)                bus.err_timeout <= 1'b0;

      if (state == ISSUE)                              timer <= '0;
      else if (state == WAIT_DONE && !bus.cnn_done)    timer <= timer + TMR_W'(1);

      if (next_state == ISSUE) begin
        bus.cnn_x     <= nx;
        bus.cnn_y     <= ny;
        bus.cnn_imgin <= win_c;
      end

      if (state == WAIT_DONE && bus.cnn_done) begin
        bus.res_class <= bus.cnn_out;
        bus.res_x     <= bus.cnn_x;
        bus.res_y     <= bus.cnn_y;
      end
    end
  end
endmodule

// File: tb/tb_cnn_window_feeder.sv
// Self-checking bench: frame loader, behavioural CNN core with selectable DONE timing,
// and a scoreboard of expected results keyed by the bench's own window walk.
module tb_cnn_window_feeder;
  typedef struct packed {
    logic [3:0] cls;
    logic [4:0] x;
    logic [4:0] y;
  } res_t;

  logic clk;
  logic rst_n;
  cnn_window_feeder_if bus ();

  cnn_window_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;
  int   frame_kind = 0;
  logic [7:0] model_pix [784];
  res_t sb_q [$];
  int   res_cnt = 0;
  res_t last_res;
  int   cd_cnt;
  int   exp_x;
  int   exp_y;
  res_t pend;
  logic prev_res_valid;
  logic prev_start;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int kind, input int i);
    case (kind)
      0:       return 8'(i % 256);
      1:       return 8'((i * 7 + 3) % 256);
      2:       return 8'((i * 13 + 5) % 256);
      default: return 8'(255 - (i % 256));
    endcase
  endfunction

  function automatic logic [199:0] exp_win(input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int k = 0; k < 5; k++)
      for (int l = 0; l < 5; l++)
        w[(k*5 + l)*8 +: 8] = model_pix[(y + k)*28 + x + l];
    return w;
  endfunction

  function automatic logic [3:0] exp_cls(input int m, input int x, input int y);
    if (m == 2) return 4'((x * 3 + y) % 16);
    return 4'((x + y) % 10);
  endfunction

  // Behavioural core plus result monitor, all sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n || !bus.busy) begin
      bus.cnn_done = 1'b0;
      bus.cnn_out  = 4'h0;
      cd_cnt = 0;
      exp_x  = 0;
      exp_y  = 0;
      if (!rst_n) sb_q.delete();
    end else begin
      bus.cnn_done = 1'b0;
      if (cd_cnt != 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          bus.cnn_done = 1'b1;
          bus.cnn_out  = pend.cls;
          sb_q.push_back(pend);
        end
      end
      if (bus.cnn_start) begin
        check_val("start_x", 256'(bus.cnn_x), 256'(exp_x));
        check_val("start_y", 256'(bus.cnn_y), 256'(exp_y));
        check_val("imgin", 256'(bus.cnn_imgin), 256'(exp_win(exp_x, exp_y)));
        if (frame_kind == 0 && exp_x == 3 && exp_y == 2) begin
          check_val("win32_b0", 256'(bus.cnn_imgin[7:0]), 256'(59));
          check_val("win32_b1", 256'(bus.cnn_imgin[15:8]), 256'(60));
          check_val("win32_b24", 256'(bus.cnn_imgin[199:192]), 256'(175));
        end
        pend.cls = exp_cls(mode, exp_x, exp_y);
        pend.x   = 5'(exp_x);
        pend.y   = 5'(exp_y);
        if (mode == 0) cd_cnt = 2;
        else if (mode == 2) begin
          cd_cnt = 3;
          bus.cnn_done = 1'b1;
          bus.cnn_out  = 4'hF;
        end
        if (exp_x == 23) begin exp_x = 0; exp_y++; end
        else exp_x++;
      end
    end

    if (bus.cnn_start) check_val("start_one_cycle", 256'(prev_start), 256'(0));
    if (bus.res_valid) begin
      if (sb_q.size() == 0) begin
        check_val("res_unexpected", 256'(1), 256'(0));
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check_val("res_class", 256'(bus.res_class), 256'(e.cls));
        check_val("res_x", 256'(bus.res_x), 256'(e.x));
        check_val("res_y", 256'(bus.res_y), 256'(e.y));
      end
      last_res = {bus.res_class, bus.res_x, bus.res_y};
      res_cnt++;
    end
    if (bus.frame_done) check_val("frame_done_after_last", 256'(prev_res_valid), 256'(1));
    prev_res_valid = bus.res_valid;
    prev_start     = bus.cnn_start;
  end

  task automatic load_frame(input int kind, input int first, input int go_at, input logic hold);
    for (int i = first; i < 784; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.pix_valid = 1'b0;
        bus.go        = 1'b0;
        @(negedge clk);
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_val(kind, i);
      bus.go        = (i == go_at);
      model_pix[i]  = pix_val(kind, i);
      @(negedge clk);
    end
    bus.go        = 1'b0;
    bus.pix_valid = hold;
    bus.pix_data  = 8'hA5;
    check_val("ready_low_after_load", 256'(bus.pix_ready), 256'(0));
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check_val("busy_after_go", 256'(bus.busy), 256'(1));
  endtask

  task automatic run_sweep(input logic [3:0] last_cls);
    int base;
    logic seen;
    base = res_cnt;
    seen = 1'b0;
    for (int n = 0; n < 576 * 8 + 50 && !seen; n++) begin
      @(negedge clk);
      if (res_cnt - base >= 100) bus.pix_valid = 1'b0;
      if (bus.frame_done) seen = 1'b1;
    end
    bus.pix_valid = 1'b0;
    check_val("frame_done_seen", 256'(seen), 256'(1));
    check_val("result_count", 256'(res_cnt - base), 256'(576));
    check_val("busy_at_frame_done", 256'(bus.busy), 256'(0));
    check_val("ready_at_frame_done", 256'(bus.pix_ready), 256'(1));
    check_val("last_res", 256'(last_res), 256'({last_cls, 5'd23, 5'd23}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pix_ready"}, 256'(bus.pix_ready), 256'(1));
    check_val({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check_val({tag, "_start"}, 256'(bus.cnn_start), 256'(0));
    check_val({tag, "_xy"}, 256'({bus.cnn_x, bus.cnn_y}), 256'(0));
    check_val({tag, "_imgin"}, 256'(bus.cnn_imgin), 256'(0));
    check_val({tag, "_res"}, 256'({bus.res_valid, bus.res_class, bus.res_x, bus.res_y}), 256'(0));
    check_val({tag, "_frame_done"}, 256'(bus.frame_done), 256'(0));
    check_val({tag, "_err"}, 256'(bus.err_timeout), 256'(0));
  endtask

  initial begin
    int n;
    int base;
    logic hit;
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    bus.go        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 0: GO during load is ignored, pixels held valid during the sweep
    mode = 0; frame_kind = 0;
    load_frame(0, 0, 400, 1'b1);
    repeat (3) @(negedge clk);
    check_val("go_in_load_ignored", 256'(bus.busy), 256'(0));
    pulse_go();
    run_sweep(4'd6);

    // Core never answers
    mode = 1; frame_kind = 1;
    load_frame(1, 0, -1, 1'b0);
    base = res_cnt;
    pulse_go();
    n = 0;
    for (int i = 0; i < 400 && bus.busy; i++) begin
      @(negedge clk);
      n++;
    end
    check_val("timeout_cycles", 256'(n), 256'(256));
    check_val("timeout_err", 256'(bus.err_timeout), 256'(1));
    check_val("timeout_ready", 256'(bus.pix_ready), 256'(1));
    check_val("timeout_no_result", 256'(res_cnt - base), 256'(0));
    repeat (4) @(negedge clk);
    check_val("timeout_no_frame_done", 256'(bus.frame_done), 256'(0));
    check_val("err_sticky", 256'(bus.err_timeout), 256'(1));

    // First accepted pixel clears the sticky flag
    bus.pix_valid = 1'b1;
    bus.pix_data  = pix_val(2, 0);
    model_pix[0]  = pix_val(2, 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check_val("err_cleared", 256'(bus.err_timeout), 256'(0));

    // DONE with START is ignored, the later DONE is captured
    mode = 2; frame_kind = 2;
    load_frame(2, 1, -1, 1'b0);
    pulse_go();
    run_sweep(4'd12);

    // Reset mid-sweep at window (10,5)
    mode = 0; frame_kind = 3;
    load_frame(3, 0, -1, 1'b0);
    pulse_go();
    hit = 1'b0;
    for (int i = 0; i < 576 * 8 && !hit; i++) begin
      if (bus.cnn_start && bus.cnn_x == 5'd10 && bus.cnn_y == 5'd5) hit = 1'b1;
      else @(negedge clk);
    end
    check_val("reached_10_5", 256'(hit), 256'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh load restarts the walk at (0,0)
    frame_kind = 0;
    load_frame(0, 0, -1, 1'b0);
    pulse_go();
    run_sweep(4'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
